// File: rtl/reg_status_table.sv
// Register result-status table for the Tomasulo issue stage.
// Each architectural register holds {busy, tag}: whether a result is pending
// and which ROB tag will produce it. Lookups are registered with same-cycle
// commit forwarding; a multi-cycle walker clears the table after a flush.
module reg_status_table #(
    parameter int NUM_REGS        = 32,
    parameter int TAG_W           = 4,
    parameter int FLUSH_PER_CYCLE = 8,
    localparam int RIDX_W         = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [RIDX_W-1:0] alloc_reg,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              commit_en,
    input  logic [RIDX_W-1:0] commit_reg,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              flush,
    output logic              ready,
    input  logic              lookup_req,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    output logic              lookup_valid,
    output logic              q1_busy,
    output logic [TAG_W-1:0]  q1_tag,
    output logic              q2_busy,
    output logic [TAG_W-1:0]  q2_tag,
    input  logic [RIDX_W-1:0] rob_query_reg,
    output logic              rob_query_busy,
    output logic [TAG_W-1:0]  rob_query_tag
);

    // The walker steps through the table in whole chunks of FLUSH_PER_CYCLE.
    localparam int NCHUNK = NUM_REGS / FLUSH_PER_CYCLE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     chunk;
    logic              busy_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];

    logic              act;
    logic              alloc_ok, commit_ok;
    logic              rs1_in, rs2_in, cr_in, ar_in, qr_in;
    logic              n1_busy, n2_busy;
    logic [TAG_W-1:0]  n1_tag, n2_tag;

    // Issue is held off during the walk and in the cycle that starts it.
    assign ready = (state == S_IDLE) && !flush;
    assign act   = ready;

    // Index range checks; only matter for non-power-of-two NUM_REGS.
    assign rs1_in = int'(rs1) < NUM_REGS;
    assign rs2_in = int'(rs2) < NUM_REGS;
    assign cr_in  = int'(commit_reg) < NUM_REGS;
    assign ar_in  = int'(alloc_reg) < NUM_REGS;
    assign qr_in  = int'(rob_query_reg) < NUM_REGS;

    // Accepted alloc/commit this cycle; register 0 is never written.
    always_comb begin
        alloc_ok  = act && alloc_en && ar_in && (alloc_reg != '0);
        commit_ok = 1'b0;
        if (act && commit_en && cr_in && (commit_reg != '0))
            commit_ok = busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag);
    end

    // Lookup results: a matching commit forwards as cleared, but a coinciding
    // alloc to the same register is not forwarded so the issuing instruction
    // still sees the previous producer of its own destination.
    always_comb begin
        n1_busy = 1'b0;
        n1_tag  = '0;
        n2_busy = 1'b0;
        n2_tag  = '0;
        if (rs1_in && busy_q[rs1]) begin
            n1_busy = 1'b1;
            n1_tag  = tag_q[rs1];
        end
        if (rs2_in && busy_q[rs2]) begin
            n2_busy = 1'b1;
            n2_tag  = tag_q[rs2];
        end
        if (commit_ok && (commit_reg == rs1) && !(alloc_ok && (alloc_reg == rs1))) begin
            n1_busy = 1'b0;
            n1_tag  = '0;
        end
        if (commit_ok && (commit_reg == rs2) && !(alloc_ok && (alloc_reg == rs2))) begin
            n2_busy = 1'b0;
            n2_tag  = '0;
        end
    end

    // Unbypassed view of the registered table for the ROB.
    always_comb begin
        rob_query_busy = 1'b0;
        rob_query_tag  = '0;
        if (qr_in && busy_q[rob_query_reg]) begin
            rob_query_busy = 1'b1;
            rob_query_tag  = tag_q[rob_query_reg];
        end
    end

    // FSM, table updates, flush walker and registered lookup outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            chunk        <= '0;
            lookup_valid <= 1'b0;
            q1_busy      <= 1'b0;
            q1_tag       <= '0;
            q2_busy      <= 1'b0;
            q2_tag       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        state        <= S_FLUSH;
                        chunk        <= '0;
                        lookup_valid <= 1'b0;
                    end else begin
                        // Commit first so a same-register alloc overrides it.
                        if (commit_ok) begin
                            busy_q[commit_reg] <= 1'b0;
                            tag_q[commit_reg]  <= '0;
                        end
                        if (alloc_ok) begin
                            busy_q[alloc_reg] <= 1'b1;
                            tag_q[alloc_reg]  <= alloc_tag;
                        end
                        lookup_valid <= lookup_req;
                        if (lookup_req) begin
                            q1_busy <= n1_busy;
                            q1_tag  <= n1_tag;
                            q2_busy <= n2_busy;
                            q2_tag  <= n2_tag;
                        end
                    end
                end
                S_FLUSH: begin
                    lookup_valid <= 1'b0;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (i / FLUSH_PER_CYCLE == int'(chunk)) begin
                            busy_q[i] <= 1'b0;
                            tag_q[i]  <= '0;
                        end
                    end
                    if (int'(chunk) == NCHUNK - 1) begin
                        state <= S_IDLE;
                        chunk <= '0;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Randomized bench for reg_status_table with a scoreboard-style table model.
module tb_reg_status_table;

    localparam int NR  = 32;
    localparam int TW  = 4;
    localparam int FPC = 8;
    localparam int RW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alloc_en = 1'b0, commit_en = 1'b0, flush = 1'b0, lookup_req = 1'b0;
    logic [RW-1:0] alloc_reg = '0, commit_reg = '0, rs1 = '0, rs2 = '0, rob_query_reg = '0;
    logic [TW-1:0] alloc_tag = '0, commit_tag = '0;
    logic          ready, lookup_valid, q1_busy, q2_busy, rob_query_busy;
    logic [TW-1:0] q1_tag, q2_tag, rob_query_tag;

    reg_status_table #(.NUM_REGS(NR), .TAG_W(TW), .FLUSH_PER_CYCLE(FPC)) dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_tag(commit_tag),
        .flush(flush), .ready(ready),
        .lookup_req(lookup_req), .rs1(rs1), .rs2(rs2),
        .lookup_valid(lookup_valid),
        .q1_busy(q1_busy), .q1_tag(q1_tag), .q2_busy(q2_busy), .q2_tag(q2_tag),
        .rob_query_reg(rob_query_reg), .rob_query_busy(rob_query_busy),
        .rob_query_tag(rob_query_tag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: table contents plus remaining walk cycles.
    bit      m_busy [NR];
    int      m_tag  [NR];
    int      m_walk = 0;
    bit      m_lv = 0, m_q1b = 0, m_q2b = 0;
    int      m_q1t = 0, m_q2t = 0;

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", t, obs, exp);
        end
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_step();
        bit old_b [NR];
        int old_t [NR];
        int base;
        if (rst) begin
            foreach (m_busy[i]) begin m_busy[i] = 0; m_tag[i] = 0; end
            m_walk = 0; m_lv = 0; m_q1b = 0; m_q2b = 0; m_q1t = 0; m_q2t = 0;
        end else if (m_walk > 0) begin
            base = (NR / FPC - m_walk) * FPC;
            for (int i = base; i < base + FPC; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
            m_walk--;
            m_lv = 0;
        end else if (flush) begin
            m_walk = NR / FPC;
            m_lv = 0;
        end else begin
            old_b = m_busy;
            old_t = m_tag;
            if (commit_en && commit_reg != 0 && m_busy[commit_reg] && m_tag[commit_reg] == int'(commit_tag)) begin
                m_busy[commit_reg] = 0; m_tag[commit_reg] = 0;
            end
            if (alloc_en && alloc_reg != 0) begin
                m_busy[alloc_reg] = 1; m_tag[alloc_reg] = int'(alloc_tag);
            end
            m_lv = lookup_req;
            if (lookup_req) begin
                if (alloc_en && alloc_reg == rs1 && rs1 != 0) begin m_q1b = old_b[rs1]; m_q1t = old_t[rs1]; end
                else begin m_q1b = m_busy[rs1]; m_q1t = m_tag[rs1]; end
                if (alloc_en && alloc_reg == rs2 && rs2 != 0) begin m_q2b = old_b[rs2]; m_q2t = old_t[rs2]; end
                else begin m_q2b = m_busy[rs2]; m_q2t = m_tag[rs2]; end
            end
        end
    endtask

    // One clock: check ready, step the model, check registered outputs.
    task automatic cyc();
        #1;
        if (!rst) chk("ready", ready, (m_walk == 0 && !flush));
        model_step();
        @(posedge clk);
        #1;
        chk("lookup_valid", lookup_valid, m_lv);
        chk("q1_busy", q1_busy, m_q1b);
        chk("q1_tag", q1_tag, m_q1t);
        chk("q2_busy", q2_busy, m_q2b);
        chk("q2_tag", q2_tag, m_q2t);
        chk("rq_busy", rob_query_busy, m_busy[rob_query_reg]);
        chk("rq_tag", rob_query_tag, m_tag[rob_query_reg]);
        rst = 0; alloc_en = 0; commit_en = 0; lookup_req = 0; flush = 0;
    endtask

    task automatic alloc(input int r, input int t);
        alloc_en = 1; alloc_reg = RW'(r); alloc_tag = TW'(t); cyc();
    endtask

    task automatic commit(input int r, input int t);
        commit_en = 1; commit_reg = RW'(r); commit_tag = TW'(t); cyc();
    endtask

    task automatic look(input int a, input int b);
        lookup_req = 1; rs1 = RW'(a); rs2 = RW'(b); cyc();
    endtask

    task automatic scan_clear(input string t);
        for (int i = 0; i < NR; i++) begin
            rob_query_reg = RW'(i);
            #1;
            chk(t, rob_query_busy, 1'b0);
        end
    endtask

    task automatic fill_all();
        for (int i = 1; i < NR; i++) alloc(i, i % 16);
    endtask

    initial begin
        int n;
        foreach (m_busy[i]) begin m_busy[i] = 0; m_tag[i] = 0; end
        @(posedge clk); #1;
        rst = 1; cyc();
        rst = 1; cyc();

        // Lookup after reset.
        look(5, 0);
        chk("tp1_valid", lookup_valid, 1'b1);
        chk("tp1_q1b", q1_busy, 1'b0);
        chk("tp1_ready", ready, 1'b1);

        // Alloc then lookup / ROB query.
        rob_query_reg = 7;
        alloc(7, 3);
        chk("tp2_rqb", rob_query_busy, 1'b1);
        chk("tp2_rqt", rob_query_tag, 3);
        look(7, 0);
        chk("tp2_q1t", q1_tag, 3);
        cyc();
        chk("tp2_valid_drop", lookup_valid, 1'b0);

        // WAW rename and stale commit.
        alloc(7, 9);
        commit(7, 3);
        chk("tp3_stale", rob_query_tag, 9);
        commit(7, 9);
        chk("tp3_clear", rob_query_busy, 1'b0);

        // Self-read on issue sees the previous producer.
        rob_query_reg = 4;
        alloc(4, 6);
        alloc_en = 1; alloc_reg = 4; alloc_tag = 2; lookup_req = 1; rs1 = 4; rs2 = 0; cyc();
        chk("tp4_old", q1_tag, 6);
        look(4, 4);
        chk("tp4_new", q1_tag, 2);
        commit_en = 1; commit_reg = 4; commit_tag = 2; lookup_req = 1; rs1 = 4; cyc();
        chk("tp4_fwd_commit", q1_busy, 1'b0);

        // Register 0 hardwired; alloc beats commit on same register.
        rob_query_reg = 0;
        alloc(0, 5);
        chk("tp5_r0", rob_query_busy, 1'b0);
        rob_query_reg = 9;
        alloc(9, 1);
        alloc_en = 1; alloc_reg = 9; alloc_tag = 12; commit_en = 1; commit_reg = 9; commit_tag = 1; cyc();
        chk("tp5_alloc_wins", rob_query_tag, 12);

        // Full flush walk; allocs during the walk are dropped.
        fill_all();
        flush = 1;
        #1 chk("flush_ready_comb", ready, 1'b0);
        cyc();
        n = 0;
        while (!ready && n < 20) begin
            alloc_en = 1; alloc_reg = 5; alloc_tag = 7; flush = 1;
            n++;
            cyc();
            #1;
        end
        chk("flush_cycles", n, 4);
        scan_clear("flush_clear");

        // Reset in the middle of a walk.
        fill_all();
        flush = 1; cyc();
        cyc();
        rst = 1; cyc();
        chk("rst_walk_ready", ready, 1'b1);
        scan_clear("rst_walk_clear");

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            alloc_en   = ($urandom_range(99) < 45);
            alloc_reg  = RW'($urandom);
            alloc_tag  = TW'($urandom);
            commit_en  = ($urandom_range(99) < 45);
            commit_reg = RW'($urandom);
            commit_tag = ($urandom_range(1)) ? TW'(m_tag[commit_reg]) : TW'($urandom);
            lookup_req = ($urandom_range(99) < 60);
            rs1        = ($urandom_range(3) == 0) ? alloc_reg : RW'($urandom);
            rs2        = ($urandom_range(3) == 0) ? commit_reg : RW'($urandom);
            flush      = ($urandom_range(99) < 2);
            rst        = ($urandom_range(999) < 4);
            rob_query_reg = RW'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
